// File: rtl/weight_pingpong_buffer_if.sv
// Loader/consumer bundle of the ping-pong weight buffer; master is the
// environment that loads and streams, slave is the buffer itself.
interface weight_pingpong_buffer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int MEM_LEN    = 16,
    parameter int MEM_DEPTH  = 16
);
    localparam int ROW_W  = DATA_WIDTH * MEM_LEN;
    localparam int ADDR_W = $clog2(MEM_DEPTH);

    // Handshakes: a write/commit takes effect only on an edge where wr_ready_o=1,
    // a stream_start only where stream_ready_o=1; otherwise it is dropped, never
    // queued. rd_valid_o qualifies rd_data_o/rd_row_o/rd_last_o for one cycle and
    // has no backpressure.
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ROW_W-1:0]  wr_data_i;
    logic              wr_commit;
    logic              wr_ready_o;
    logic              stream_start;
    logic              stream_ready_o;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [ROW_W-1:0]  rd_data_o;
    logic              rd_valid_o;
    logic [ADDR_W-1:0] rd_row_o;
    logic              rd_last_o;
    logic              busy_o;

    modport master (
        output wr_en, wr_addr, wr_data_i, wr_commit, stream_start, rd_en, rd_addr,
        input  wr_ready_o, stream_ready_o, rd_data_o, rd_valid_o, rd_row_o, rd_last_o, busy_o
    );

    modport slave (
        input  wr_en, wr_addr, wr_data_i, wr_commit, stream_start, rd_en, rd_addr,
        output wr_ready_o, stream_ready_o, rd_data_o, rd_valid_o, rd_row_o, rd_last_o, busy_o
    );
endinterface

// File: rtl/weight_pingpong_buffer.sv
// Double-buffered weight store: the shadow bank is loaded while the active bank
// is streamed row by row or read at random; a committed shadow swaps in when idle.
module weight_pingpong_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int MEM_LEN    = 16,
    parameter int MEM_DEPTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    weight_pingpong_buffer_if.slave   bus
);
    localparam int ROW_W  = DATA_WIDTH * MEM_LEN;
    localparam int ADDR_W = $clog2(MEM_DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(MEM_DEPTH - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t            state;
    logic              bank_sel;
    logic              shadow_full;
    logic              active_valid;
    logic [ADDR_W-1:0] cnt;
    logic [ROW_W-1:0]  rd_data;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_row;
    logic              rd_last;

    logic [ROW_W-1:0]  mem [2][MEM_DEPTH];

    logic wr_ready;
    logic stream_ready;
    logic start_acc;
    logic wr_in_range;
    logic rd_in_range;

    assign wr_ready     = ~shadow_full;
    assign stream_ready = (state == IDLE) && active_valid && !shadow_full;
    assign start_acc    = bus.stream_start && stream_ready;
    assign wr_in_range  = {1'b0, bus.wr_addr} < DEPTH_C;
    assign rd_in_range  = {1'b0, bus.rd_addr} < DEPTH_C;

    // Storage carries no reset; the shadow bank is always ~bank_sel so loads never
    // touch the rows being streamed.
    always_ff @(posedge clk) begin
        if (bus.wr_en && wr_ready && wr_in_range) begin
            mem[~bank_sel][bus.wr_addr] <= bus.wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bank_sel     <= 1'b0;
            shadow_full  <= 1'b0;
            active_valid <= 1'b0;
            cnt          <= '0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            rd_row       <= '0;
            rd_last      <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            if (bus.wr_commit && wr_ready) begin
                shadow_full <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start_acc) begin
                        state <= STREAM;
                        cnt   <= '0;
                    end else begin
                        // A swap can only happen while shadow_full blocks commits,
                        // so it never races the commit above.
                        if (shadow_full) begin
                            bank_sel     <= ~bank_sel;
                            shadow_full  <= 1'b0;
                            active_valid <= 1'b1;
                        end
                        if (bus.rd_en) begin
                            rd_data  <= rd_in_range ? mem[bank_sel][bus.rd_addr] : '0;
                            rd_row   <= bus.rd_addr;
                            rd_valid <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    rd_data  <= mem[bank_sel][cnt];
                    rd_row   <= cnt;
                    rd_valid <= 1'b1;
                    // Leaving on the edge that presents the last row lets the next
                    // start be sampled while rd_last_o is still visible.
                    if (cnt == LAST_ROW) begin
                        rd_last <= 1'b1;
                        state   <= IDLE;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.wr_ready_o     = wr_ready;
    assign bus.stream_ready_o = stream_ready;
    assign bus.rd_data_o      = rd_data;
    assign bus.rd_valid_o     = rd_valid;
    assign bus.rd_row_o       = rd_row;
    assign bus.rd_last_o      = rd_last;
    assign bus.busy_o         = (state == STREAM);
endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// Directed bench for weight_pingpong_buffer: a 16x16x16 instance and a 12-row,
// 4x8-bit instance, each with its own expected-output queue and monitor.
module tb_weight_pingpong_buffer;
    localparam int DW  = 16;
    localparam int ML  = 16;
    localparam int MD  = 16;
    localparam int RW  = DW * ML;
    localparam int AW  = 4;
    localparam int MW  = RW + AW + 1;
    localparam int SDW = 8;
    localparam int SML = 4;
    localparam int SMD = 12;
    localparam int SRW = SDW * SML;
    localparam int SAW = 4;
    localparam int SW  = SRW + SAW + 1;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    logic [MW-1:0] exp_q[$];
    logic [SW-1:0] sexp_q[$];

    weight_pingpong_buffer_if #(.DATA_WIDTH(DW), .MEM_LEN(ML), .MEM_DEPTH(MD)) m ();
    weight_pingpong_buffer_if #(.DATA_WIDTH(SDW), .MEM_LEN(SML), .MEM_DEPTH(SMD)) s ();

    weight_pingpong_buffer #(.DATA_WIDTH(DW), .MEM_LEN(ML), .MEM_DEPTH(MD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (m.slave)
    );

    weight_pingpong_buffer #(.DATA_WIDTH(SDW), .MEM_LEN(SML), .MEM_DEPTH(SMD)) dut_small (
        .clk (clk),
        .rst (rst),
        .bus (s.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // helpers and driver tasks
    function automatic logic [RW-1:0] rep_m(input logic [DW-1:0] v);
        logic [RW-1:0] r;
        r = '0;
        for (int i = 0; i < ML; i++) r[i*DW +: DW] = v;
        return r;
    endfunction

    function automatic logic [SRW-1:0] rep_s(input logic [SDW-1:0] v);
        logic [SRW-1:0] r;
        r = '0;
        for (int i = 0; i < SML; i++) r[i*SDW +: SDW] = v;
        return r;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_m();
        m.wr_en = 0; m.wr_addr = '0; m.wr_data_i = '0; m.wr_commit = 0;
        m.stream_start = 0; m.rd_en = 0; m.rd_addr = '0;
    endtask

    task automatic idle_s();
        s.wr_en = 0; s.wr_addr = '0; s.wr_data_i = '0; s.wr_commit = 0;
        s.stream_start = 0; s.rd_en = 0; s.rd_addr = '0;
    endtask

    task automatic write_m(input int row, input logic [RW-1:0] data, input logic commit);
        m.wr_en = 1; m.wr_addr = AW'(row); m.wr_data_i = data; m.wr_commit = commit;
        step();
        m.wr_en = 0; m.wr_commit = 0;
    endtask

    task automatic write_s(input int row, input logic [SRW-1:0] data);
        s.wr_en = 1; s.wr_addr = SAW'(row); s.wr_data_i = data;
        step();
        s.wr_en = 0;
    endtask

    task automatic push_m(input int row, input logic last, input logic [RW-1:0] data);
        exp_q.push_back({AW'(row), last, data});
    endtask

    task automatic push_s(input int row, input logic last, input logic [SRW-1:0] data);
        sexp_q.push_back({SAW'(row), last, data});
    endtask

    // scoreboard monitors
    always @(negedge clk) begin
        if (m.rd_valid_o) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL m_unexpected_valid: got row=%0d last=%0b, expected no output",
                         m.rd_row_o, m.rd_last_o);
            end else begin
                logic [MW-1:0] e;
                e = exp_q.pop_front();
                if ({m.rd_row_o, m.rd_last_o, m.rd_data_o} !== e) begin
                    n_errors++;
                    $display("FAIL m_rd_out: got row=%0d last=%0b data=%h, expected row=%0d last=%0b data=%h",
                             m.rd_row_o, m.rd_last_o, m.rd_data_o, e[MW-1 -: AW], e[RW], e[RW-1:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (s.rd_valid_o) begin
            n_checks++;
            if (sexp_q.size() == 0) begin
                n_errors++;
                $display("FAIL s_unexpected_valid: got row=%0d last=%0b, expected no output",
                         s.rd_row_o, s.rd_last_o);
            end else begin
                logic [SW-1:0] e;
                e = sexp_q.pop_front();
                if ({s.rd_row_o, s.rd_last_o, s.rd_data_o} !== e) begin
                    n_errors++;
                    $display("FAIL s_rd_out: got row=%0d last=%0b data=%h, expected row=%0d last=%0b data=%h",
                             s.rd_row_o, s.rd_last_o, s.rd_data_o, e[SW-1 -: SAW], e[SRW], e[SRW-1:0]);
                end
            end
        end
    end

    // stimulus
    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1;
        idle_m();
        idle_s();
        repeat (2) step();
        chk("rst_valid", 64'(m.rd_valid_o), 0);
        chk("rst_busy", 64'(m.busy_o), 0);
        chk("rst_sready", 64'(m.stream_ready_o), 0);
        chk("rst_wready", 64'(m.wr_ready_o), 1);
        chk("rst_data", m.rd_data_o[63:0], 0);
        rst = 0;
        step();

        // load first bank, commit, swap latency
        for (int r = 0; r < MD; r++) write_m(r, rep_m(DW'(r + 1)), 1'b0);
        m.wr_commit = 1;
        step();
        m.wr_commit = 0;
        chk("commit_t1_wready", 64'(m.wr_ready_o), 0);
        chk("commit_t1_sready", 64'(m.stream_ready_o), 0);
        step();
        chk("swap_t2_wready", 64'(m.wr_ready_o), 1);
        chk("swap_t2_sready", 64'(m.stream_ready_o), 1);

        // first half of the next bank before the stream, the rest during it
        for (int r = 0; r < 8; r++) write_m(r, rep_m(DW'(16'hA0 + r)), 1'b0);
        for (int k = 0; k < MD; k++) push_m(k, k == MD - 1, rep_m(DW'(k + 1)));
        m.stream_start = 1;
        step();
        m.stream_start = 0;
        chk("stream1_busy", 64'(m.busy_o), 1);
        for (int i = 0; i < MD; i++) begin
            if (i < 8) begin
                m.wr_en = 1; m.wr_addr = AW'(8 + i); m.wr_data_i = rep_m(DW'(16'hA8 + i));
                m.wr_commit = (i == 7);
            end else if (i == 9) begin
                chk("full_wready", 64'(m.wr_ready_o), 0);
                m.wr_en = 1; m.wr_addr = AW'(3); m.wr_data_i = {RW{1'b1}};
            end else begin
                m.wr_en = 0; m.wr_commit = 0;
            end
            step();
        end
        idle_m();
        chk("end1_busy", 64'(m.busy_o), 0);
        chk("end1_no_swap_yet", 64'(m.wr_ready_o), 0);
        chk("end1_sready", 64'(m.stream_ready_o), 0);
        step();
        chk("deferred_swap_wready", 64'(m.wr_ready_o), 1);
        chk("deferred_swap_sready", 64'(m.stream_ready_o), 1);

        // dropped write must not have reached row 3
        push_m(3, 1'b0, rep_m(16'hA3));
        m.rd_en = 1; m.rd_addr = AW'(3);
        step();
        m.rd_en = 0;
        chk("rd_latency", 64'(m.rd_valid_o), 1);
        step();
        chk("rd_hold_valid", 64'(m.rd_valid_o), 0);
        chk("rd_hold_data", 64'(m.rd_data_o == rep_m(16'hA3)), 1);

        // start beats a simultaneous read; reads during the stream are ignored
        for (int k = 0; k < MD; k++) push_m(k, k == MD - 1, rep_m(DW'(16'hA0 + k)));
        m.rd_en = 1; m.rd_addr = AW'(5); m.stream_start = 1;
        step();
        m.stream_start = 0;
        chk("stream2_busy", 64'(m.busy_o), 1);
        chk("stream_wins_no_rd", 64'(m.rd_valid_o), 0);
        for (int i = 0; i < MD; i++) step();
        m.rd_en = 0;
        chk("back_to_back_sready", 64'(m.stream_ready_o), 1);

        // back-to-back stream, then async reset at row 7
        for (int k = 0; k < MD; k++) push_m(k, k == MD - 1, rep_m(DW'(16'hA0 + k)));
        m.stream_start = 1;
        step();
        m.stream_start = 0;
        for (int i = 0; i < 8; i++) step();
        #2 rst = 1;
        #1;
        chk("async_rst_valid", 64'(m.rd_valid_o), 0);
        chk("async_rst_data", m.rd_data_o[63:0], 0);
        chk("async_rst_row", 64'(m.rd_row_o), 0);
        chk("async_rst_busy", 64'(m.busy_o), 0);
        exp_q.delete();
        step();
        rst = 0;
        step();
        chk("post_rst_sready", 64'(m.stream_ready_o), 0);
        chk("post_rst_valid", 64'(m.rd_valid_o), 0);
        chk("post_rst_wready", 64'(m.wr_ready_o), 1);

        // small instance: non-power-of-two depth
        for (int r = 0; r < SMD; r++) write_s(r, rep_s(SDW'(8'h10 + r)));
        write_s(13, 32'hDEADBEEF);
        s.wr_commit = 1;
        step();
        s.wr_commit = 0;
        step();
        chk("s_sready", 64'(s.stream_ready_o), 1);
        for (int k = 0; k < SMD; k++) push_s(k, k == SMD - 1, rep_s(SDW'(8'h10 + k)));
        s.stream_start = 1;
        step();
        s.stream_start = 0;
        for (int i = 0; i < SMD; i++) step();
        chk("s_end_last", 64'(s.rd_last_o), 1);
        chk("s_end_row", 64'(s.rd_row_o), 11);
        step();
        chk("s_no_row12", 64'(s.rd_valid_o), 0);
        push_s(13, 1'b0, '0);
        s.rd_en = 1; s.rd_addr = SAW'(13);
        step();
        push_s(11, 1'b0, rep_s(8'h1B));
        s.rd_addr = SAW'(11);
        step();
        s.rd_en = 0;
        repeat (3) step();

        chk("m_queue_drained", 64'(exp_q.size()), 0);
        chk("s_queue_drained", 64'(sexp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
